// File: rtl/bus_arb_pkg.sv
// Shared types and default constants for the system bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  localparam int GRANT_WAIT_DEF = 16;
  localparam int MAX_HOLD_DEF   = 1024;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: returns the first requesting index after 'last',
// wrapping modulo NREQ. Purely combinational.
module rr_picker #(
  parameter  int NREQ = 3,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  pick,
  output logic            any
);

  logic [IDW-1:0] w_idx;

  // Scan from the farthest candidate back to last+1 so the nearest one wins
  always_comb begin
    pick  = '0;
    w_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = IDW'((int'(last) + i) % NREQ);
      if (req[w_idx]) pick = w_idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared system bus.
// Optional feature: define BUS_ARB_WATCHDOG_EN to revoke a grant whose busy
// stays high for MAX_HOLD cycles and pulse err; otherwise err is tied low.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NREQ       = 3,
  parameter  int GRANT_WAIT = GRANT_WAIT_DEF,
  parameter  int MAX_HOLD   = MAX_HOLD_DEF,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] busy,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  owner,
  output logic            err
);

  localparam int WAIT_W = $clog2(GRANT_WAIT + 1);

  arb_state_t        r_state, w_state_nxt;
  logic [IDW-1:0]    r_owner, w_owner_nxt;
  logic [IDW-1:0]    r_last, w_last_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic [IDW-1:0]    w_pick_last, w_pick;
  logic              w_any;
  logic [NREQ-1:0]   w_grant;
`ifdef BUS_ARB_WATCHDOG_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic              r_err, w_err_nxt;
`endif

  // In TURN the outgoing owner becomes the new round-robin reference immediately
  assign w_pick_last = (r_state == TURN) ? r_owner : r_last;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req  (req),
    .last (w_pick_last),
    .pick (w_pick),
    .any  (w_any)
  );

  // Next-state and next-register logic for the ownership FSM
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_wait_nxt  = r_wait_cnt;
`ifdef BUS_ARB_WATCHDOG_EN
    w_hold_nxt  = r_hold_cnt;
    w_err_nxt   = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_pick;
          w_wait_nxt  = '0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        if (busy[r_owner]) begin
          w_state_nxt = BUSY;
          w_wait_nxt  = '0;
`ifdef BUS_ARB_WATCHDOG_EN
          w_hold_nxt  = '0;
`endif
        end else if (!req[r_owner]) begin
          w_state_nxt = TURN;
        end else if (r_wait_cnt == WAIT_W'(GRANT_WAIT - 1)) begin
          w_state_nxt = TURN;
        end
      end
      BUSY: begin
`ifdef BUS_ARB_WATCHDOG_EN
        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
`endif
        if (!busy[r_owner]) begin
          w_state_nxt = TURN;
`ifdef BUS_ARB_WATCHDOG_EN
        end else if (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = TURN;
`endif
        end
      end
      TURN: begin
        w_last_nxt = r_owner;
        w_wait_nxt = '0;
`ifdef BUS_ARB_WATCHDOG_EN
        w_hold_nxt = '0;
`endif
        if (w_any) begin
          w_owner_nxt = w_pick;
          w_state_nxt = GRANT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and bookkeeping registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= IDW'(NREQ - 1);
      r_wait_cnt <= '0;
`ifdef BUS_ARB_WATCHDOG_EN
      r_hold_cnt <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_wait_cnt <= w_wait_nxt;
`ifdef BUS_ARB_WATCHDOG_EN
      r_hold_cnt <= w_hold_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  // One-hot grant decoded from registered state only
  always_comb begin
    w_grant = '0;
    if (r_state == GRANT || r_state == BUSY) w_grant[r_owner] = 1'b1;
  end

  assign grant       = w_grant;
  assign grant_valid = |w_grant;
  assign owner       = r_owner;
`ifdef BUS_ARB_WATCHDOG_EN
  assign err         = r_err;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic, compared against a rule-level ownership model.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int NREQ = 3;
  localparam int GW   = 16;
  localparam int MH   = 1024;
`ifdef BUS_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] busy = '0;
  logic [2:0] grant;
  logic       grant_valid;
  logic [1:0] owner;
  logic       err;

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  bus_arbiter #(.NREQ(NREQ), .GRANT_WAIT(GW), .MAX_HOLD(MH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .busy        (busy),
    .grant       (grant),
    .grant_valid (grant_valid),
    .owner       (owner),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // Reference model: who owns the bus, how long they have had it, whether
  // their transaction has started, and whether this is the gap cycle.
  int m_own;    // -1 when nobody holds the grant
  int m_disp;   // most recent owner (shown on 'owner')
  int m_last;   // round-robin reference
  int m_age;
  int m_hold;
  bit m_turn;
  bit m_busy;
  bit m_err;

  function automatic bit bit_of(input logic [2:0] v, input int k);
    return ((v >> k) & 3'd1) != 3'd0;
  endfunction

  function automatic int rr_next(input int lastv, input logic [2:0] r);
    for (int i = 1; i <= NREQ; i++) begin
      if (bit_of(r, (lastv + i) % NREQ)) return (lastv + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_disp = 0; m_last = NREQ - 1; m_age = 0; m_hold = 0;
    m_turn = 1'b0; m_busy = 1'b0; m_err = 1'b0;
  endtask

  task automatic give(input int p);
    m_own = p; m_disp = p; m_age = 0; m_hold = 0; m_busy = 1'b0;
  endtask

  task automatic release_bus();
    m_own = -1; m_turn = 1'b1;
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] b);
    int p;
    m_err = 1'b0;
    if (m_turn) begin
      m_turn = 1'b0;
      m_last = m_disp;
      p = rr_next(m_last, r);
      if (p >= 0) give(p);
    end else if (m_own < 0) begin
      p = rr_next(m_last, r);
      if (p >= 0) give(p);
    end else if (!m_busy) begin
      if (bit_of(b, m_own)) begin m_busy = 1'b1; m_hold = 0; end
      else if (!bit_of(r, m_own) || m_age == GW - 1) release_bus();
      else m_age++;
    end else begin
      if (!bit_of(b, m_own)) release_bus();
      else if (WD && m_hold == MH - 1) begin m_err = 1'b1; release_bus(); end
      else m_hold++;
    end
  endtask

  function automatic logic [2:0] exp_grant();
    return (m_own >= 0) ? (3'b001 << m_own) : 3'b000;
  endfunction

  // One clock: drive at negedge, model at posedge, compare at the next negedge
  task automatic cyc(input logic [2:0] r, input logic [2:0] b);
    req = r; busy = b;
    @(posedge clk);
    model_step(r, b);
    @(negedge clk);
    chk("grant", grant, exp_grant());
    chk("grant_valid", grant_valid, (m_own >= 0));
    chk("owner", owner, m_disp);
    chk("err", err, m_err);
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; busy = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [2:0] seq_exp [4];
  logic [2:0] r_rand;
  int held, zeros, errs;

  initial begin
    model_reset();
    #1;
    phase = "reset";
    chk("grant", grant, 3'b000);
    chk("grant_valid", grant_valid, 1'b0);
    chk("owner", owner, 2'd0);
    chk("err", err, 1'b0);

    // Async reset in the middle of a BUSY transaction
    phase = "t1";
    do_reset();
    cyc(3'b010, 3'b000);
    cyc(3'b010, 3'b010);
    chk("busy_grant", grant, 3'b010);
    #2 reset = 1'b0;
    #1;
    chk("async_grant", grant, 3'b000);
    chk("async_valid", grant_valid, 1'b0);
    chk("async_err", err, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(3'b000, 3'b000);
      chk("stay_idle", grant, 3'b000);
    end

    // Single requester, 1-cycle latency, grant held through busy
    phase = "t2";
    do_reset();
    cyc(3'b010, 3'b000);
    chk("first_grant", grant, 3'b010);
    chk("first_owner", owner, 2'd1);
    for (int i = 0; i < 8; i++) cyc(3'b010, 3'b010);
    chk("held_grant", grant, 3'b010);
    cyc(3'b010, 3'b000);
    chk("turn_gap", grant, 3'b000);
    cyc(3'b000, 3'b000);
    chk("idle_after", grant, 3'b000);
    chk("owner_kept", owner, 2'd1);

    // All requesting: rotation with one empty cycle between owners
    phase = "t3";
    seq_exp[0] = 3'b001; seq_exp[1] = 3'b010; seq_exp[2] = 3'b100; seq_exp[3] = 3'b001;
    do_reset();
    cyc(3'b111, 3'b000);
    for (int k = 0; k < 4; k++) begin
      chk("rot_grant", grant, seq_exp[k]);
      if (k < 3) begin
        cyc(3'b111, seq_exp[k]);
        cyc(3'b111, seq_exp[k]);
        cyc(3'b111, 3'b000);
        chk("rot_gap", grant, 3'b000);
        cyc(3'b111, 3'b000);
      end
    end

    // Owner never raises busy: revoked after GRANT_WAIT cycles
    phase = "t4";
    do_reset();
    held = 0;
    for (int i = 0; i < GW; i++) begin
      cyc(3'b011, 3'b000);
      if (grant == 3'b001) held++;
    end
    chk("wait_cycles", held, GW);
    cyc(3'b011, 3'b000);
    chk("revoked", grant, 3'b000);
    cyc(3'b011, 3'b000);
    chk("next_owner", grant, 3'b010);

    // busy wins over a simultaneous request drop
    phase = "t5";
    do_reset();
    cyc(3'b001, 3'b000);
    cyc(3'b000, 3'b001);
    chk("busy_wins", grant, 3'b001);
    cyc(3'b000, 3'b001);
    chk("still_busy", grant, 3'b001);
    cyc(3'b000, 3'b000);
    chk("released", grant, 3'b000);

    // Long transaction: watchdog revokes once, or grant is simply held
    phase = "t6";
    do_reset();
    cyc(3'b001, 3'b000);
    zeros = 0; errs = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc(3'b001, 3'b001);
      if (grant != 3'b001) zeros++;
      if (err) errs++;
    end
    chk("long_gaps", zeros, WD ? 1 : 0);
    chk("long_errs", errs, WD ? 1 : 0);

    // Randomized traffic against the model
    phase = "rand_a";
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cyc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    phase = "rand_b";
    for (int s = 0; s < 40; s++) begin
      r_rand = 3'($urandom_range(0, 7));
      for (int i = 0; i < 30; i++) begin
        cyc(r_rand, ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
